ysyx_040066_mem_arbiter: RTL and testbench

- Shares one single-outstanding memory bus between the CPU instruction-fetch port (IF, pc_rd/instr_rd) and the data port (M stage, MemRd/MemWr).
- Sits between the CPU top and the memory/bus bridge.
- Produces the CPU's instr_valid/instr_error/data_valid/data_error stall inputs.
- Results are held until the pipeline consumes them, so global stalls never lose a completed transaction or re-issue a store.

---
 rtl/ysyx_040066_mem_arbiter_pkg.sv | 30 +++
 rtl/ysyx_040066_mem_arbiter_if.sv | 38 +++
 rtl/ysyx_040066_mem_arbiter_timeout.sv | 36 +++
 rtl/ysyx_040066_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ysyx_040066_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_040066_mem_arbiter_pkg.sv
// rtl/ysyx_040066_mem_arbiter_pkg.sv - shared types and defaults for the memory arbiter
//
// Package ysyx_040066_mem_pkg:
//   arb_state_e              arbiter FSM states
//   LEN_B/LEN_H/LEN_W/LEN_D  bus size codes (1, 2, 4, 8 bytes)
//   DEF_TIMEOUT              default bus cycles before a transaction is failed
//   DEF_STARVE_MAX           default consecutive D wins before a waiting fetch is forced
//   lane_select              picks the 32-bit half of a 64-bit bus word
package ysyx_040066_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BUS   = 2'd1,
    D_BUS   = 2'd2,
    I_DRAIN = 2'd3
  } arb_state_e;

  localparam logic [2:0] LEN_B = 3'd0;
  localparam logic [2:0] LEN_H = 3'd1;
  localparam logic [2:0] LEN_W = 3'd2;
  localparam logic [2:0] LEN_D = 3'd3;

  localparam int unsigned DEF_TIMEOUT    = 255;
  localparam int unsigned DEF_STARVE_MAX = 4;

  function automatic logic [31:0] lane_select(input logic [63:0] word, input logic hi);
    return hi ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/ysyx_040066_mem_arbiter_if.sv
// rtl/ysyx_040066_mem_arbiter_if.sv - single-outstanding memory bus interface
//
// Signals:
//   req    transaction active; all request fields stable while high
//   wen    write enable
//   addr   64-bit address
//   wdata  64-bit write data
//   wmask  byte write mask
//   len    size code
//   resp   single-cycle completion
//   rdata  read data, valid with resp
//   err    error flag, valid with resp
// Modports:
//   master  arbiter side (drives request fields)
//   slave   memory/bridge side (drives response fields)
interface ysyx_040066_mem_arbiter_if;

  logic        req;
  logic        wen;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic [2:0]  len;
  logic        resp;
  logic [63:0] rdata;
  logic        err;

  modport master (
    output req, wen, addr, wdata, wmask, len,
    input  resp, rdata, err
  );

  modport slave (
    input  req, wen, addr, wdata, wmask, len,
    output resp, rdata, err
  );

endinterface

// File: rtl/ysyx_040066_mem_arbiter_timeout.sv
// rtl/ysyx_040066_mem_arbiter_timeout.sv - loadable saturating cycle counter with done flag
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        restart the count from zero
//   en          count one cycle
//   done        count has reached LIMIT (holds there until load)
module ysyx_040066_arb_timeout
  import ysyx_040066_mem_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT - 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !done) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == W'(LIMIT));

endmodule

// File: rtl/ysyx_040066_mem_arbiter.sv
// rtl/ysyx_040066_mem_arbiter.sv - IF/MEM arbiter for a single-outstanding memory bus
//
// Shares one memory bus between instruction fetch and the data port. Completed
// results are held until the pipeline consumes them, so stalls never lose a
// result or re-issue a store.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   i_req/i_addr/i_flush/i_consume     fetch request, redirect, result accept
//   i_rdata/i_valid/i_error            held fetch result
//   d_rd/d_wr/d_addr/d_wdata/d_wmask   load/store request
//   d_len/d_consume                    size code, result accept
//   d_rdata/d_valid/d_error            held data result
//   bus (master)                       req/wen/addr/wdata/wmask/len out, resp/rdata/err in
module ysyx_040066_mem_arbiter
  import ysyx_040066_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  input  logic        i_flush,
  input  logic        i_consume,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  output logic        i_error,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_wmask,
  input  logic [2:0]  d_len,
  input  logic        d_consume,
  output logic [63:0] d_rdata,
  output logic        d_valid,
  output logic        d_error,
  ysyx_040066_mem_arbiter_if.master bus
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_e    state;
  logic [SW-1:0] starve_cnt;
  logic          i_hold;
  logic          d_hold;

  logic i_pend, d_pend, starved, grant_d, grant_i;
  logic tmo_load, tmo_done, finish;

  // A held result blocks re-arbitration of its own port; this is what keeps a
  // stalled store from being issued a second time.
  assign i_pend  = i_req & ~i_hold & ~i_flush;
  assign d_pend  = (d_rd | d_wr) & ~d_hold;
  assign starved = (starve_cnt == SW'(STARVE_MAX));
  assign grant_d = (state == IDLE) & d_pend & ~(i_pend & starved);
  assign grant_i = (state == IDLE) & i_pend & ~grant_d;

  // The counter restarts on every state entry: it sits at zero while idle and
  // is reloaded when a flushed fetch moves into the drain state.
  assign tmo_load = (state == IDLE) | ((state == I_BUS) & i_flush);
  assign finish   = bus.resp | tmo_done;

  ysyx_040066_arb_timeout #(
    .LIMIT (TIMEOUT - 1)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmo_load),
    .en    (1'b1),
    .done  (tmo_done)
  );

  assign i_valid = i_hold;
  assign d_valid = d_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      i_hold     <= 1'b0;
      d_hold     <= 1'b0;
      i_rdata    <= '0;
      i_error    <= 1'b0;
      d_rdata    <= '0;
      d_error    <= 1'b0;
      bus.req    <= 1'b0;
      bus.wen    <= 1'b0;
      bus.addr   <= '0;
      bus.wdata  <= '0;
      bus.wmask  <= '0;
      bus.len    <= '0;
    end else begin
      if (i_flush || (i_consume && i_hold)) begin
        i_hold  <= 1'b0;
        i_error <= 1'b0;
      end
      if (d_consume && d_hold) begin
        d_hold  <= 1'b0;
        d_error <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= D_BUS;
            starve_cnt <= i_pend ? starve_cnt + 1'b1 : '0;
            bus.req    <= 1'b1;
            bus.wen    <= d_wr;
            bus.addr   <= d_addr;
            bus.wdata  <= d_wdata;
            bus.wmask  <= d_wmask;
            bus.len    <= d_len;
          end else if (grant_i) begin
            state      <= I_BUS;
            starve_cnt <= '0;
            bus.req    <= 1'b1;
            bus.wen    <= 1'b0;
            bus.addr   <= i_addr;
            bus.wdata  <= '0;
            bus.wmask  <= '0;
            bus.len    <= LEN_W;
          end
        end

        I_BUS: begin
          if (i_flush) begin
            // A redirect throws the fetch away; if the bus has not answered
            // yet we still have to wait for it before issuing anything else.
            if (finish) begin
              state   <= IDLE;
              bus.req <= 1'b0;
            end else begin
              state <= I_DRAIN;
            end
          end else if (finish) begin
            state   <= IDLE;
            bus.req <= 1'b0;
            i_hold  <= 1'b1;
            i_rdata <= bus.resp ? lane_select(bus.rdata, bus.addr[2]) : 32'd0;
            i_error <= bus.resp ? bus.err : 1'b1;
          end
        end

        D_BUS: begin
          if (finish) begin
            state   <= IDLE;
            bus.req <= 1'b0;
            d_hold  <= 1'b1;
            d_rdata <= bus.resp ? bus.rdata : 64'd0;
            d_error <= bus.resp ? bus.err : 1'b1;
          end
        end

        I_DRAIN: begin
          if (finish) begin
            state   <= IDLE;
            bus.req <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          bus.req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_040066_mem_arbiter.sv
// tb/tb_ysyx_040066_mem_arbiter.sv - randomized self-checking bench for the memory arbiter
module tb_ysyx_040066_mem_arbiter;
  import ysyx_040066_mem_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req, i_flush, i_consume, i_valid, i_error;
  logic [63:0] i_addr;
  logic [31:0] i_rdata;
  logic        d_rd, d_wr, d_consume, d_valid, d_error;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic [7:0]  d_wmask;
  logic [2:0]  d_len;

  ysyx_040066_mem_arbiter_if bus();

  ysyx_040066_mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_consume(i_consume),
    .i_rdata(i_rdata), .i_valid(i_valid), .i_error(i_error),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_len(d_len), .d_consume(d_consume),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_error(d_error),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [2:0]  len;
  } txn_t;

  txn_t        log_q[$];
  txn_t        rec;
  int          resp_delay = 0;
  bit          resp_err   = 1'b0;
  bit          use_fixed  = 1'b0;
  bit          stray      = 1'b0;
  logic [63:0] fixed_word = '0;
  int          req_age    = 0;

  // Memory contents as seen by the bench: a fixed hash of the address.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0] + 32'h1357_9BDF};
  endfunction

  function automatic logic [31:0] fetch_word(input logic [63:0] w, input logic [63:0] a);
    logic [31:0] r;
    if (a[2]) r = w[63:32];
    else r = w[31:0];
    return r;
  endfunction

  // Bus responder: logs each transaction once and answers resp_delay cycles
  // after bus_req is first seen (never when resp_delay < 0).
  initial begin : responder
    bus.resp = 1'b0; bus.rdata = '0; bus.err = 1'b0;
    forever begin
      @(negedge clk);
      bus.resp = 1'b0; bus.err = 1'b0; bus.rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      if (rst_n && bus.req) begin
        if (req_age == 0) begin
          rec.wen = bus.wen; rec.addr = bus.addr; rec.wdata = bus.wdata;
          rec.wmask = bus.wmask; rec.len = bus.len;
          log_q.push_back(rec);
        end
        if (resp_delay >= 0 && req_age == resp_delay) begin
          bus.resp = 1'b1;
          bus.rdata = use_fixed ? fixed_word : mem_word(bus.addr);
          bus.err = resp_err;
        end
        req_age++;
      end else begin
        req_age = 0;
        if (rst_n && stray) begin
          bus.resp = 1'b1; bus.rdata = 64'h0123_4567_89AB_CDEF; bus.err = 1'b1;
        end
      end
    end
  end

  task automatic idle_inputs();
    i_req = 0; i_addr = '0; i_flush = 0; i_consume = 0;
    d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0; d_wmask = '0; d_len = '0; d_consume = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if ({bus.req, i_valid, d_valid, i_error, d_error} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {bus.req, i_valid, d_valid, i_error, d_error}); end
    n_tests++; if ({i_rdata, d_rdata} !== 96'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", {i_rdata, d_rdata}); end
    n_tests++; if ({bus.wen, bus.addr, bus.wdata, bus.wmask, bus.len} !== 140'd0) begin n_fail++; $display("FAIL reset_bus: got %h expected 0", {bus.wen, bus.addr, bus.wdata, bus.wmask, bus.len}); end
    rst_n = 1'b1;
    stray = 1'b1;
    repeat (4) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    n_tests++; if ({i_valid, d_valid, bus.req} !== 3'b000 || log_q.size() != 0) begin n_fail++; $display("FAIL idle_stray_resp: got valid=%b%b req=%b txns=%0d expected 000 0", i_valid, d_valid, bus.req, log_q.size()); end
  endtask

  task automatic test_i_only();
    int stall_bad = 0;
    log_q.delete(); use_fixed = 1; fixed_word = 64'h1111_2222_3333_4444; resp_delay = 0; resp_err = 0;
    i_addr = 64'h8000_0004; i_req = 1;
    @(negedge clk);
    n_tests++; if ({bus.req, bus.wen, bus.len} !== {1'b1, 1'b0, 3'd2} || bus.addr !== 64'h8000_0004) begin n_fail++; $display("FAIL i_only_bus: got req=%b wen=%b len=%0d addr=%h expected 1 0 2 80000004", bus.req, bus.wen, bus.len, bus.addr); end
    n_tests++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL i_only_early_valid: got %b expected 0", i_valid); end
    @(negedge clk);
    i_req = 0;
    n_tests++; if ({i_valid, i_error, bus.req} !== 3'b100 || i_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL i_only_result: got v/e/req=%b rdata=%h expected 100 11112222", {i_valid, i_error, bus.req}, i_rdata); end
    repeat (5) begin @(negedge clk); if (!i_valid || i_rdata !== 32'h1111_2222) stall_bad++; end
    n_tests++; if (stall_bad != 0) begin n_fail++; $display("FAIL i_only_hold: got %0d dropped cycles expected 0", stall_bad); end
    i_consume = 1; @(negedge clk); i_consume = 0;
    n_tests++; if (i_valid !== 1'b0 || log_q.size() != 1) begin n_fail++; $display("FAIL i_only_consume: got valid=%b txns=%0d expected 0 1", i_valid, log_q.size()); end
    use_fixed = 0;
  endtask

  task automatic test_contention();
    int stall_bad = 0; int writes = 0; int lat = 0;
    logic [63:0] wd;
    wd = {$urandom, $urandom};
    log_q.delete(); resp_delay = 1; resp_err = 0;
    d_wr = 1; d_addr = 64'h8000_1000; d_wdata = wd; d_wmask = 8'hFF; d_len = LEN_D;
    i_req = 1; i_addr = 64'h8000_0100;
    @(negedge clk);
    n_tests++; if ({bus.req, bus.wen} !== 2'b11 || bus.addr !== 64'h8000_1000 || bus.wdata !== wd || bus.wmask !== 8'hFF) begin n_fail++; $display("FAIL contention_d_first: got req/wen=%b addr=%h wdata=%h mask=%h expected 11 80001000 %h ff", {bus.req, bus.wen}, bus.addr, bus.wdata, bus.wmask, wd); end
    while (!d_valid && lat < 20) begin @(negedge clk); lat++; end
    n_tests++; if (d_valid !== 1'b1) begin n_fail++; $display("FAIL contention_d_done: got %b expected 1", d_valid); end
    repeat (10) begin @(negedge clk); if (!d_valid) stall_bad++; end
    n_tests++; if (stall_bad != 0) begin n_fail++; $display("FAIL contention_d_hold: got %0d dropped cycles expected 0", stall_bad); end
    d_consume = 1; d_wr = 0;
    @(negedge clk); d_consume = 0;
    lat = 0;
    while (!i_valid && lat < 20) begin @(negedge clk); lat++; end
    repeat (3) @(negedge clk);
    foreach (log_q[k]) if (log_q[k].wen) writes++;
    n_tests++; if (writes != 1 || log_q.size() != 2) begin n_fail++; $display("FAIL contention_store_once: got writes=%0d txns=%0d expected 1 2", writes, log_q.size()); end
    n_tests++; if (log_q.size() < 2 || log_q[0].wen !== 1'b1 || log_q[1].wen !== 1'b0 || log_q[1].addr !== 64'h8000_0100) begin n_fail++; $display("FAIL contention_order: got %0d txns expected D write then I fetch at 80000100", log_q.size()); end
    n_tests++; if (i_valid !== 1'b1 || i_rdata !== fetch_word(mem_word(64'h8000_0100), 64'h8000_0100)) begin n_fail++; $display("FAIL contention_fetch: got v=%b rdata=%h expected 1 %h", i_valid, i_rdata, fetch_word(mem_word(64'h8000_0100), 64'h8000_0100)); end
    i_consume = 1; i_req = 0; @(negedge clk); i_consume = 0;
  endtask

  task automatic test_starvation();
    localparam logic [63:0] IADDR = 64'h8000_3000;
    localparam logic [63:0] DBASE = 64'h8000_4000;
    bit iw = 1; int run = 0; int nd_m = 0; int exp_code = 1; int act_code = 1;
    bit i_served = 0; int nd = 0; int dk = 0; int addr_bad = 0; int cyc = 0;
    while (nd_m < 6 || iw) begin
      if (iw && run == STARVE_MAX) begin exp_code = exp_code * 2 + 1; iw = 0; run = 0; end
      else begin exp_code = exp_code * 2; nd_m++; run = iw ? run + 1 : 0; end
    end
    log_q.delete(); resp_delay = 1; resp_err = 0;
    i_req = 1; i_addr = IADDR; d_rd = 1; d_addr = DBASE; d_len = LEN_D;
    while (cyc < 400 && !(nd == 6 && i_served)) begin
      @(negedge clk); cyc++;
      d_consume = d_valid; i_consume = i_valid;
      i_flush = d_valid && !i_served;
      if (i_valid) begin i_served = 1; i_req = 0; end
      if (d_valid) begin nd++; d_addr = DBASE + 64'(8 * nd); if (nd == 6) d_rd = 0; end
    end
    @(negedge clk);
    idle_inputs();
    n_tests++; if (cyc >= 400) begin n_fail++; $display("FAIL starvation_bound: got d_done=%0d i_done=%0d expected 6 1", nd, i_served); end
    foreach (log_q[k]) begin
      act_code = act_code * 2 + ((log_q[k].addr == IADDR) ? 1 : 0);
      if (log_q[k].addr != IADDR) begin if (log_q[k].addr != DBASE + 64'(8 * dk)) addr_bad++; dk++; end
    end
    n_tests++; if (act_code != exp_code) begin n_fail++; $display("FAIL starvation_order: got code %b expected %b (1=I 0=D)", act_code, exp_code); end
    n_tests++; if (addr_bad != 0) begin n_fail++; $display("FAIL starvation_d_addr: got %0d wrong addresses expected 0", addr_bad); end
  endtask

  task automatic test_flush();
    localparam logic [63:0] OLD = 64'h8000_0200;
    localparam logic [63:0] NEW = 64'h8000_2004;
    int dly[2] = '{3, 0};
    foreach (dly[j]) begin
      int highs = 0; int bad = 0; int lat = 0;
      log_q.delete(); resp_delay = dly[j]; resp_err = 0;
      i_addr = OLD; i_req = 1;
      @(negedge clk);
      n_tests++; if (bus.req !== 1'b1 || bus.addr !== OLD) begin n_fail++; $display("FAIL flush_grant_d%0d: got req=%b addr=%h expected 1 %h", dly[j], bus.req, bus.addr, OLD); end
      i_flush = 1; i_addr = NEW;
      @(negedge clk); i_flush = 0;
      while (bus.req && highs < 20) begin
        if (i_valid || bus.addr !== OLD) bad++;
        highs++; @(negedge clk);
      end
      n_tests++; if (highs != dly[j] || bad != 0) begin n_fail++; $display("FAIL flush_drain_d%0d: got %0d drain cycles bad=%0d expected %0d 0", dly[j], highs, bad, dly[j]); end
      while (!i_valid && lat < 20) begin @(negedge clk); lat++; end
      n_tests++; if (i_valid !== 1'b1 || log_q.size() != 2 || i_rdata !== fetch_word(mem_word(NEW), NEW)) begin n_fail++; $display("FAIL flush_refetch_d%0d: got v=%b txns=%0d rdata=%h expected 1 2 %h", dly[j], i_valid, log_q.size(), i_rdata, fetch_word(mem_word(NEW), NEW)); end
      i_consume = 1; i_req = 0; @(negedge clk); i_consume = 0;
    end
  endtask

  task automatic test_timeout();
    int highs = 0;
    log_q.delete(); resp_delay = -1;
    d_rd = 1; d_addr = 64'h8000_5008; d_len = LEN_W;
    @(negedge clk);
    while (bus.req && highs < 400) begin highs++; @(negedge clk); end
    n_tests++; if (highs != TIMEOUT) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected %0d", highs, TIMEOUT); end
    n_tests++; if ({d_valid, d_error, bus.req} !== 3'b110 || d_rdata !== 64'd0) begin n_fail++; $display("FAIL timeout_result: got v/e/req=%b rdata=%h expected 110 0", {d_valid, d_error, bus.req}, d_rdata); end
    d_consume = 1; d_rd = 0; @(negedge clk); d_consume = 0;
    n_tests++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_consume: got %b expected 0", d_valid); end
    resp_delay = 0;
  endtask

  task automatic test_async_reset();
    int lat = 0;
    log_q.delete(); resp_delay = 0; resp_err = 0;
    i_req = 1; i_addr = 64'h8000_0010;
    while (!i_valid && lat < 20) begin @(negedge clk); lat++; end
    i_req = 0;
    resp_delay = -1; d_rd = 1; d_addr = 64'h8000_6000; d_len = LEN_D;
    @(negedge clk); @(negedge clk);
    n_tests++; if ({bus.req, i_valid} !== 2'b11) begin n_fail++; $display("FAIL areset_setup: got req/i_valid=%b expected 11", {bus.req, i_valid}); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({bus.req, d_valid, i_valid} !== 3'b000) begin n_fail++; $display("FAIL areset_clear: got req/d_valid/i_valid=%b expected 000", {bus.req, d_valid, i_valid}); end
    idle_inputs();
    @(negedge clk); rst_n = 1'b1; resp_delay = 0;
    @(negedge clk);
    log_q.delete();
    d_rd = 1; d_addr = 64'h8000_6100; d_len = LEN_D;
    lat = 0;
    while (!d_valid && lat < 20) begin @(negedge clk); lat++; end
    n_tests++; if (lat != 2 || d_rdata !== mem_word(64'h8000_6100) || log_q.size() != 1) begin n_fail++; $display("FAIL areset_resume: got lat=%0d rdata=%h txns=%0d expected 2 %h 1", lat, d_rdata, log_q.size(), mem_word(64'h8000_6100)); end
    d_consume = 1; d_rd = 0; @(negedge clk); d_consume = 0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int kind; int dly; bit err; int lat = 0;
      logic [63:0] a, wd; logic [7:0] wm; logic [2:0] ln;
      kind = $urandom_range(0, 2); dly = $urandom_range(0, 4); err = ($urandom_range(0, 3) == 0);
      a = {32'h0, $urandom}; wd = {$urandom, $urandom}; wm = 8'($urandom); ln = 3'($urandom_range(0, 3));
      log_q.delete(); resp_delay = dly; resp_err = err;
      if (kind == 0) begin
        a[1:0] = 2'b00; i_addr = a; i_req = 1;
        while (!i_valid && lat < 30) begin @(negedge clk); lat++; end
        n_tests++; if (lat != dly + 2 || i_rdata !== fetch_word(mem_word(a), a) || i_error !== err) begin n_fail++; $display("FAIL rand_fetch_%0d: got lat=%0d rdata=%h err=%b expected %0d %h %b", it, lat, i_rdata, i_error, dly + 2, fetch_word(mem_word(a), a), err); end
        n_tests++; if (log_q.size() != 1 || log_q[0].wen !== 1'b0 || log_q[0].addr !== a || log_q[0].len !== 3'd2) begin n_fail++; $display("FAIL rand_fetch_bus_%0d: got %0d txns expected one read of %h len 2", it, log_q.size(), a); end
      end else begin
        d_addr = a; d_wdata = wd; d_wmask = wm; d_len = ln; d_rd = (kind == 1); d_wr = (kind == 2);
        while (!d_valid && lat < 30) begin @(negedge clk); lat++; end
        n_tests++; if (lat != dly + 2 || d_rdata !== mem_word(a) || d_error !== err) begin n_fail++; $display("FAIL rand_data_%0d: got lat=%0d rdata=%h err=%b expected %0d %h %b", it, lat, d_rdata, d_error, dly + 2, mem_word(a), err); end
        n_tests++; if (log_q.size() != 1 || log_q[0] !== {(kind == 2), a, wd, wm, ln}) begin n_fail++; $display("FAIL rand_data_bus_%0d: got %0d txns expected one with wen=%0d addr=%h", it, log_q.size(), kind == 2, a); end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      i_consume = i_valid; d_consume = d_valid; i_req = 0; d_rd = 0; d_wr = 0;
      @(negedge clk);
      i_consume = 0; d_consume = 0;
      n_tests++; if ({i_valid, d_valid, bus.req} !== 3'b000) begin n_fail++; $display("FAIL rand_release_%0d: got %b expected 000", it, {i_valid, d_valid, bus.req}); end
    end
    resp_err = 0; resp_delay = 0;
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_contention();
    test_starvation();
    test_flush();
    test_timeout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
